// File: rtl/usb_buf_pkg.sv
// Shared types and sizing for the USB packet data buffer.
// DEPTH must stay a power of two so the pointers wrap for free.
package usb_buf_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OCC_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_FILL  = 3'd1,
        TX_DRAIN = 3'd2,
        RX_FILL  = 3'd3,
        RX_DRAIN = 3'd4
    } buf_state_t;

endpackage

// File: rtl/usb_buf_ram.sv
// DEPTH x 8 flop array: one write port, one combinational read port.
// The array resets to zero, so reads are defined straight out of reset.
module usb_buf_ram
    import usb_buf_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer_ctrl.sv
// Packet buffer shared by the AHB slave and the USB TX/RX engines.
// An ownership FSM decides which side may write or read the buffer.
//
//   state    | meaning
//   IDLE     | empty, unowned; the first write claims it
//   TX_FILL  | AHB filling a TX packet
//   TX_DRAIN | USB TX engine reading the packet out
//   RX_FILL  | USB RX engine filling a received packet
//   RX_DRAIN | AHB reading the received packet out
module usb_data_buffer_ctrl
    import usb_buf_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    output logic [7:0]       rx_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buffer_full,
    output logic             buffer_empty,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             conflict_err
);

    buf_state_t        state, state_next;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [OCC_W-1:0]  occ, occ_next;
    logic              wr_ahb, wr_usb, rd_ahb, rd_usb;
    logic              wr_ok, rd_ok;
    logic              ovf, unf, cfl;
    logic [7:0]        rdata;

    assign buffer_full  = (occ == OCC_W'(DEPTH));
    assign buffer_empty = (occ == '0);
    assign wr_ok        = wr_ahb | wr_usb;
    assign rd_ok        = rd_ahb | rd_usb;
    assign occ_next     = occ + OCC_W'(wr_ok) - OCC_W'(rd_ok);

    always_comb begin
        state_next = state;
        wr_ahb     = 1'b0;
        wr_usb     = 1'b0;
        rd_ahb     = 1'b0;
        rd_usb     = 1'b0;
        ovf        = 1'b0;
        unf        = 1'b0;
        cfl        = 1'b0;
        if (!clear) begin
            case (state)
                IDLE: begin
                    unf = get_rx_data | get_tx_packet_data;
                    if (store_rx_packet_data) begin
                        wr_usb     = 1'b1;
                        cfl        = store_tx_data;
                        state_next = RX_FILL;
                    end else if (store_tx_data) begin
                        wr_ahb     = 1'b1;
                        state_next = TX_FILL;
                    end
                end
                TX_FILL: begin
                    cfl = store_rx_packet_data | get_rx_data;
                    if (store_tx_data) begin
                        ovf    = buffer_full;
                        wr_ahb = !buffer_full;
                    end
                    if (get_tx_packet_data) begin
                        unf    = buffer_empty;
                        rd_usb = !buffer_empty;
                        if (!buffer_empty) state_next = TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    cfl = store_tx_data | store_rx_packet_data | get_rx_data;
                    if (get_tx_packet_data) begin
                        unf    = buffer_empty;
                        rd_usb = !buffer_empty;
                    end
                end
                RX_FILL: begin
                    cfl = store_tx_data | get_tx_packet_data;
                    if (store_rx_packet_data) begin
                        ovf    = buffer_full;
                        wr_usb = !buffer_full;
                    end
                    if (get_rx_data) begin
                        unf    = buffer_empty;
                        rd_ahb = !buffer_empty;
                        if (!buffer_empty) state_next = RX_DRAIN;
                    end
                end
                RX_DRAIN: begin
                    cfl = store_tx_data | store_rx_packet_data | get_tx_packet_data;
                    if (get_rx_data) begin
                        unf    = buffer_empty;
                        rd_ahb = !buffer_empty;
                    end
                end
                default: state_next = IDLE;
            endcase
            // Any read that empties the buffer releases ownership, so a
            // fill state read of the last byte cannot strand a drain state.
            if (rd_ok && occ_next == '0) state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            occ           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            conflict_err  <= 1'b0;
        end else begin
            overflow_err  <= ovf;
            underflow_err <= unf;
            conflict_err  <= cfl;
            if (clear) begin
                state <= IDLE;
                wptr  <= '0;
                rptr  <= '0;
                occ   <= '0;
            end else begin
                state <= state_next;
                occ   <= occ_next;
                if (wr_ok) wptr <= wptr + ADDR_W'(1);
                if (rd_ok) rptr <= rptr + ADDR_W'(1);
            end
        end
    end

    usb_buf_ram u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (wr_usb ? rx_packet_data : tx_data),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign rx_data          = rdata;
    assign tx_packet_data   = rdata;
    assign buffer_occupancy = occ;

endmodule

// File: doc/usb_data_buffer_ctrl.md
Name: usb_data_buffer_ctrl

Overview:
Owns and sequences the 64-byte packet data buffer shared between the AHB-Lite slave and the USB TX/RX protocol engines.
- Arbitrates one write port and one read port between the AHB side (store_tx_data, get_rx_data) and the USB side (store_rx_packet_data, get_tx_packet_data).
- Enforces buffer ownership through an ownership FSM.
- Reports buffer_occupancy back to the AHB slave status registers.
- Drives error pulses for rejected accesses.

Parameters:
DEPTH, 64, number of byte entries in the buffer (power of two)
ADDR_W, 6, log2(DEPTH), width of the read/write pointers
OCC_W, 7, ADDR_W+1, width of the occupancy count (range 0..DEPTH)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous flush request (AHB flush register, or USB RX start)
store_tx_data  in  1  AHB-side byte write strobe
tx_data  in  8  AHB-side write byte
get_rx_data  in  1  AHB-side byte read strobe
rx_data  out  8  AHB-side read byte, head of buffer
store_rx_packet_data  in  1  USB RX byte write strobe
rx_packet_data  in  8  USB RX write byte
get_tx_packet_data  in  1  USB TX byte read strobe
tx_packet_data  out  8  USB TX read byte, head of buffer
buffer_occupancy  out  OCC_W  bytes currently held
buffer_full  out  1  occupancy == DEPTH
buffer_empty  out  1  occupancy == 0
overflow_err  out  1  one-cycle pulse: write rejected because full
underflow_err  out  1  one-cycle pulse: read rejected because empty
conflict_err  out  1  one-cycle pulse: access rejected by ownership

Behaviour:
- Reset (async, n_rst low): wptr=0, rptr=0, occupancy=0, state=IDLE.
  - All error pulses 0; buffer_empty=1; buffer_full=0.
  - rx_data and tx_packet_data read 0, because storage resets to 0.
- Read data is show-ahead.
  - rx_data = tx_packet_data = mem[rptr], combinational, valid in the same cycle as the strobe.
  - rptr advances on the clock edge of an accepted read.
- Accepted write: mem[wptr] <= byte; wptr++.
- Pointers wrap modulo DEPTH.
- Occupancy update per cycle: +1 per accepted write, -1 per accepted read. An accepted write and an accepted read in the same cycle leave occupancy unchanged.
- Ownership FSM states: IDLE, TX_FILL, TX_DRAIN, RX_FILL, RX_DRAIN.
  - IDLE (buffer empty):
    - store_tx_data -> TX_FILL (write accepted).
    - store_rx_packet_data -> RX_FILL (write accepted).
    - Both in the same cycle: USB wins, AHB write dropped, conflict_err=1.
    - Any read in IDLE: underflow_err=1, no pointer change.
  - TX_FILL:
    - AHB writes accepted.
    - get_tx_packet_data accepted -> TX_DRAIN. An AHB write in that same cycle is also accepted.
    - USB writes and AHB reads are rejected (conflict_err).
  - TX_DRAIN:
    - Only USB reads accepted.
    - The read that takes occupancy 1->0 -> IDLE.
    - AHB writes, USB writes and AHB reads are rejected (conflict_err).
  - RX_FILL: mirror of TX_FILL. USB writes accepted; get_rx_data accepted -> RX_DRAIN.
  - RX_DRAIN: mirror of TX_DRAIN. Only AHB reads accepted; last read -> IDLE.
- Error priority for a single access: ownership check first (conflict_err), then full/empty (overflow_err/underflow_err). A rejected access never moves pointers, occupancy or state.
- Write while full (occupancy==DEPTH) in an owning state: dropped, overflow_err=1.
- Read while empty in a draining state cannot occur, because the FSM leaves the state at 0. If it is forced, it is treated as underflow.
- clear has the highest priority.
  - Next edge: pointers=0, occupancy=0, state=IDLE.
  - All same-cycle strobes are ignored and raise no error.
  - Storage contents are not erased.
- Error outputs are registered: each pulse appears the cycle after the offending strobe and lasts exactly one cycle.

Decomposition:
- Shared package usb_buf_pkg holds:
  - buf_state_t enum (IDLE, TX_FILL, TX_DRAIN, RX_FILL, RX_DRAIN)
  - DEPTH, ADDR_W and OCC_W constants
- Sub-module usb_buf_ram:
  - 1-write/1-read flop array, DEPTH x 8, async reset to 0.
  - Combinational read port.
- The controller holds the pointers, occupancy, FSM and error logic.

Test Plan:
- Reset, then 4 AHB writes 0x11,0x22,0x33,0x44 -> occupancy 4, state TX_FILL. Then 4 USB reads -> tx_packet_data 0x11..0x44 in order, occupancy 0, state IDLE.
- 64 AHB writes then a 65th -> buffer_full=1, 65th dropped, overflow_err pulses once, occupancy stays 64.
- In IDLE, store_tx_data and store_rx_packet_data in the same cycle -> USB byte stored, occupancy 1, RX_FILL, conflict_err=1.
- In TX_FILL with occupancy 3, AHB write plus USB read in the same cycle -> occupancy 3, TX_DRAIN. A following AHB write is rejected with conflict_err.
- clear asserted mid-RX_FILL with occupancy 10, together with store_rx_packet_data -> occupancy 0, IDLE, buffer_empty=1, no error pulse.
- Wrap: fill 60 bytes and drain all, then fill 8 bytes and drain all -> data in order across the pointer wrap, occupancy returns to 0.
